// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity serial receiver.
package odd_parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned MAX_DATA_W = 16;

  // Width of a counter that must hold 0..dw inclusive.
  function automatic int unsigned bit_cnt_w(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_ok(input logic [MAX_DATA_W-1:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

endpackage

// File: rtl/odd_parity_rx_sync.sv
// Two-flop rxd synchroniser (idle-high reset); only built when ODD_PARITY_RX_SYNC_EN is defined.
`ifdef ODD_PARITY_RX_SYNC_EN
module odd_parity_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule
`endif

// File: rtl/odd_parity_rx.sv
// Odd-parity serial receiver: start, DATA_W bits LSB first, parity, stop; valid/ready output.
// Define ODD_PARITY_RX_SYNC_EN to pass rxd through a 2-flop synchroniser (+2 cycles latency).
module odd_parity_rx
  import odd_parity_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BCW    = bit_cnt_w(DATA_W);
  localparam int unsigned HALF_P = CLKS_PER_BIT / 2;

  logic              rxd_s;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              pbit_q;
  logic              stop_q;
  logic              done_q;
  logic              armed_q;
  logic              mid_sample;

`ifdef ODD_PARITY_RX_SYNC_EN
  odd_parity_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );
`else
  assign rxd_s = rxd;
`endif

  // Mid-bit strobe: half a period into the start bit, then every full period.
  always_comb begin
    mid_sample = 1'b0;
    case (state_q)
      START:              mid_sample = (cnt_q == CNT_W'(HALF_P - 1));
      DATA, PARITY, STOP: mid_sample = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
      default:            mid_sample = 1'b0;
    endcase
  end

  // Next-state logic; a start is only accepted once the line has been seen high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && !rxd_s) state_d = START;
      START:   if (mid_sample) state_d = rxd_s ? IDLE : DATA;
      DATA:    if (mid_sample && (bit_cnt_q == BCW'(DATA_W - 1))) state_d = PARITY;
      PARITY:  if (mid_sample) state_d = STOP;
      STOP:    if (mid_sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bit timing, deserialisation and line re-arm tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE || mid_sample) cnt_q <= '0;
      else                               cnt_q <= cnt_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (rxd_s)        armed_q <= 1'b1;
          else if (armed_q) armed_q <= 1'b0;
        end
        START: begin
          if (mid_sample && rxd_s) armed_q <= 1'b1;
        end
        DATA: begin
          if (mid_sample) begin
            shift_q   <= (shift_q >> 1) | (DATA_W'(rxd_s) << (DATA_W - 1));
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        PARITY: begin
          if (mid_sample) pbit_q <= rxd_s;
        end
        STOP: begin
          if (mid_sample) begin
            stop_q  <= rxd_s;
            armed_q <= rxd_s;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output word register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (done_q) begin
        data_out   <= shift_q;
        parity_err <= ~odd_ok(MAX_DATA_W'(shift_q), pbit_q);
        frame_err  <= ~stop_q;
        data_valid <= 1'b1;
        if (data_valid && !data_ready)     overrun <= 1'b1;
        else if (data_valid && data_ready) overrun <= 1'b0;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_odd_parity_rx.sv
// Directed self-checking bench for odd_parity_rx (DATA_W=8, CLKS_PER_BIT=16).
module tb_odd_parity_rx;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CPB    = 16;
`ifdef ODD_PARITY_RX_SYNC_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 0;
`endif
  // Edges from the start-bit launch edge to the stop-bit mid-sample.
  localparam int unsigned STOP_EDGE = 1 + CPB / 2 + CPB * (DATA_W + 2) + LAT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxd = 1'b1;
  logic              data_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  odd_parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DATA_W); i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept();
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  // Sends a frame and checks data_valid rises exactly one cycle after the stop sample.
  task automatic send_timed(input logic [7:0] d, input logic p, input logic s, input string tag);
    fork
      send_frame(d, p, s);
      begin
        repeat (STOP_EDGE) @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_pre"}, 32'(data_valid), 0);
        @(negedge clk);
        check({tag, "_valid_rise"}, 32'(data_valid), 1);
      end
    join
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic pe,
                            input logic fe, input logic ov);
    @(negedge clk);
    check({tag, "_valid"}, 32'(data_valid), 1);
    check({tag, "_data"}, 32'(data_out), 32'(d));
    check({tag, "_perr"}, 32'(parity_err), 32'(pe));
    check({tag, "_ferr"}, 32'(frame_err), 32'(fe));
    check({tag, "_ovr"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    logic seen_busy;
    logic seen_valid;
    logic found;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    align();
    rst_n = 1'b1;
    idle(4);

    // 1: clean frame, latency and hold-until-accept
    send_timed(8'hA5, 1'b1, 1'b1, "t1");
    check_word("t1", 8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t1_hold_valid", 32'(data_valid), 1);
    check("t1_hold_data", 32'(data_out), 'hA5);
    align();
    accept();
    @(negedge clk);
    check("t1_drop", 32'(data_valid), 0);

    // 2: wrong and correct parity bit
    align();
    idle(2);
    send_frame(8'h07, 1'b1, 1'b1);
    check_word("t2a", 8'h07, 1'b1, 1'b0, 1'b0);
    align();
    accept();
    idle(2);
    send_frame(8'h07, 1'b0, 1'b1);
    check_word("t2b", 8'h07, 1'b0, 1'b0, 1'b0);
    align();
    accept();

    // 3: framing error then held-low line must not retrigger
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_word("t3a", 8'h3C, 1'b0, 1'b1, 1'b0);
    align();
    accept();
    seen_busy  = 1'b0;
    seen_valid = 1'b0;
    repeat (40 * CPB) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      if (data_valid) seen_valid = 1'b1;
    end
    check("t3_break_busy", 32'(seen_busy), 0);
    check("t3_break_valid", 32'(seen_valid), 0);
    align();
    idle(3);
    send_frame(8'h3C, 1'b1, 1'b1);
    check_word("t3b", 8'h3C, 1'b0, 1'b0, 1'b0);
    align();
    accept();

    // 4: short glitch is rejected
    idle(4);
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rxd = 1'b1;
    check("t4_busy_set", 32'(busy), 1);
    found = 1'b0;
    for (int i = 0; i < 9 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check("t4_busy_clear", 32'(found), 1);
    seen_valid = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (data_valid) seen_valid = 1'b1;
    end
    check("t4_no_valid", 32'(seen_valid), 0);

    // 5: back-to-back frames without accept -> overrun
    align();
    idle(2);
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    check_word("t5", 8'h22, 1'b0, 1'b0, 1'b1);
    align();
    accept();
    @(negedge clk);
    check("t5_drop", 32'(data_valid), 0);
    check("t5_ovr_clr", 32'(overrun), 0);

    // 6: reset mid-frame discards it
    align();
    idle(2);
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      begin
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("t6_busy_mid", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_valid", 32'(data_valid), 0);
      end
    join
    idle(4);
    rst_n = 1'b1;
    idle(4);
    check("t6_no_stale", 32'(data_valid), 0);
    send_timed(8'hC3, 1'b1, 1'b1, "t6");
    check_word("t6", 8'hC3, 1'b0, 1'b0, 1'b0);
    align();
    accept();
    @(negedge clk);
    check("t6_drop", 32'(data_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
